mdu: RTL
========

# mdu

Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the single-cycle MIPS core. It consumes the two GPR read buses and the decoded mult/div/mthi/mtlo requests. It holds `busy` while an operation runs so the controller can stall mfhi/mflo and any new mult/div. Results are produced by a 32-iteration radix-2 datapath, not a combinational array.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: begin the operation selected by `op`. Sampled only when `busy`=0.
- `op`, input, 2: operation select. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `a`, input, 32: rs operand (busA). Multiplicand or dividend.
- `b`, input, 32: rt operand (busB). Multiplier or divisor.
- `mthi`, input, 1: write `wdata` into HI.
- `mtlo`, input, 1: write `wdata` into LO.
- `wdata`, input, 32: data for mthi/mtlo (busA).
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse when HI/LO have just been updated by mult/div.
- `hi`, output, 32: HI register.
- `lo`, output, 32: LO register.

## Operation
- FSM has three states:
  - IDLE: waits for a request. On `start`, go to RUN.
  - RUN: iterates; `cnt` runs 0..31. When `cnt`=31, go to DONE.
  - DONE: pulses `done`, then returns to IDLE.
- At start, latch the operand magnitudes: abs(a) and abs(b) for signed ops, raw values for unsigned ops. Record the result signs:
  - product sign = a[31]^b[31] for mult; 0 for multu.
  - quotient sign = a[31]^b[31] for div; 0 for divu.
  - remainder sign = a[31] for div; 0 for divu.
- Multiply: 64-bit shift-add over the 32 multiplier bits, one bit per cycle. At completion, {HI,LO} = the product, negated in two's complement if the product sign is set.
- Divide: restoring division over 32 quotient bits, one bit per cycle, using a 33-bit trial subtract. At completion:
  - LO = quotient, truncated toward zero.
  - HI = remainder, which takes the sign of the dividend.
- Divide by zero (b=0, div or divu): HI = a (unmodified), LO = 0xFFFF_FFFF. Run the full latency regardless.
- Signed overflow (div, 0x8000_0000 / 0xFFFF_FFFF): LO = 0x8000_0000, HI = 0.
- mthi/mtlo in IDLE: the register is written at the next edge. mthi and mtlo in the same cycle write both registers.
- mthi/mtlo while `busy` is 1 or in DONE: ignored.
- `start` and mthi/mtlo in the same IDLE cycle: `start` wins and the mthi/mtlo write is dropped.
- `start` while `busy`: ignored. `a`, `b` and `op` need not be held after the start edge.
- HI/LO keep their old values during RUN. They change only at the RUN→DONE edge or on an IDLE mthi/mtlo.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE, `cnt`=0.
- Reset asserted mid-operation: the operation is aborted and all reset values apply at that edge.
- Let E0 be the edge that samples `start`=1.
- `busy` is 1 from E0 through E32 (32 cycles).
- HI/LO are updated at E32.
- At E32, `done`=1 and `busy`=0. At E33, `done`=0 and the FSM is back in IDLE.
- A new `start` is accepted at E33 at the earliest.
- Total start-to-result latency: 32 cycles. Results are readable combinationally in the cycle after E32.
- mthi/mtlo latency: 1 edge.

## Structure
- Shared package `mips_pkg` holds:
  - the op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the FSM state encoding for IDLE, RUN and DONE;
  - the divide-by-zero LO constant 0xFFFF_FFFF.
- One sub-module: `mdu_step`. It is combinational and computes one iteration step:
  - add-and-shift for multiply;
  - trial-subtract and shift for divide.
- `mdu` itself owns the FSM, counter, sign fix-up and HI/LO registers.

## Test plan
- multu a=0xFFFF_FFFF, b=0xFFFF_FFFF → after 32 busy cycles, HI=0xFFFF_FFFE, LO=0x0000_0001, `done` pulses once.
- mult a=0xFFFF_FFFD (−3), b=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- div a=0xFFFF_FFF9 (−7), b=2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- divu a=100, b=0 → HI=100, LO=0xFFFF_FFFF. Then div 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- Start div, assert mthi wdata=0x1234 and a second `start` mid-run → both are ignored, and the result equals the undisturbed run. Then mthi=0x1234 in IDLE → HI=0x1234 after 1 edge.
- Start mult, drive `rst`=0 at cycle 10 → `busy`=0, HI=LO=0 at that edge. A following multu 3×5 → LO=15 at E32.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// op encodings, FSM states, divide-by-zero LO value and a magnitude helper.
package mips_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    // Two's-complement magnitude for signed ops; raw value for unsigned ops.
    function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute-stage controller and the MDU.
interface mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds {upper, lower}: multiply keeps the multiplier in lower, divide the dividend/quotient.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] diff_s;

    // Trial remainder stays below twice the divisor, so bit WIDTH of diff is a clean borrow flag.
    always_comb begin
        sum_s   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        trial_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff_s  = trial_s - {1'b0, opnd_i};
        if (is_div_i) begin
            if (!diff_s[WIDTH]) begin
                acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {trial_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes for 32 cycles, then applies the recorded signs once.
module mdu
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               op_signed_s;
    logic               op_div_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               load_s;
    logic [2*WIDTH-1:0] step_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_s)
    );

    // Operand decode and final sign fix-up from the last iteration's accumulator.
    always_comb begin
        op_signed_s = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        op_div_s    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
        mag_a_s     = mdu_mag(bus.a, op_signed_s);
        mag_b_s     = mdu_mag(bus.b, op_signed_s);
        load_s      = bus.start && ((state_q == MDU_IDLE) || (state_q == MDU_DONE));
        if (!is_div_q) begin
            {fin_hi_s, fin_lo_s} = neg_lo_q ? (~step_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : step_s;
        end else if (div0_q) begin
            fin_hi_s = araw_q;
            fin_lo_s = MDU_DIV0_LO;
        end else begin
            fin_hi_s = neg_hi_q ? (~step_s[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                                : step_s[2*WIDTH-1:WIDTH];
            fin_lo_s = neg_lo_q ? (~step_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                                : step_s[WIDTH-1:0];
        end
    end

    // Next-state, iteration and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            MDU_IDLE: begin
                if (load_s) begin
                    state_d = MDU_RUN;
                end else begin
                    hi_d = bus.mthi ? bus.wdata : hi_q;
                    lo_d = bus.mtlo ? bus.wdata : lo_q;
                end
            end
            MDU_RUN: begin
                acc_d = step_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = MDU_DONE;
                    cnt_d   = {CW{1'b0}};
                    hi_d    = fin_hi_s;
                    lo_d    = fin_lo_s;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            MDU_DONE: begin
                state_d = load_s ? MDU_RUN : MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        if (load_s) begin
            cnt_d    = {CW{1'b0}};
            acc_d    = {{WIDTH{1'b0}}, (op_div_s ? mag_a_s : mag_b_s)};
            opnd_d   = op_div_s ? mag_b_s : mag_a_s;
            is_div_d = op_div_s;
            neg_lo_d = op_signed_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_d = op_signed_s && op_div_s && bus.a[WIDTH-1];
            div0_d   = op_div_s && (bus.b == {WIDTH{1'b0}});
            araw_d   = bus.a;
        end else begin
            araw_d = araw_q;
        end

        busy_d = (state_d == MDU_RUN);
        done_d = (state_d == MDU_DONE);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            araw_q   <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
